// File: rtl/sprite_rom_arb.sv
// Shares one synchronous sprite ROM among N_REQ renderers and routes each returned word to its issuer.
// Build option: define SPRITE_ROM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module sprite_rom_arb #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 13,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk_vga,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*ADDR_W-1:0]   addr_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic                      rom_en_o,
  output logic [ADDR_W-1:0]         rom_addr_o,
  input  logic [DATA_W-1:0]         rom_data_i,
  output logic [DATA_W-1:0]         rd_data_o,
  output logic [N_REQ-1:0]          rd_vld_o,
  input  logic                      v_sync_i,
  output logic [15:0]               conflict_cnt_o
);

  logic [N_REQ-1:0]  gnt_d;
  logic              pick_found;
  logic [ADDR_W-1:0] addr_sel;
  logic [3:0]        req_cnt;
  logic              contention;
  logic              vs_fall;

  logic              rom_en_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [N_REQ-1:0]  tag_q [ROM_LAT+1];
  logic [DATA_W-1:0] rd_data_q;
  logic [N_REQ-1:0]  rd_vld_q;
  logic              vs_q;
  logic [15:0]       cnt_q;
  logic [15:0]       cnt_d;

`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_d      = '0;
    pick_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_found && req_i[k]) begin
        gnt_d[k]   = 1'b1;
        pick_found = 1'b1;
      end
    end
  end
`else
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // First pass covers indices at/after the pointer, second pass wraps to the lowest active one.
  always_comb begin
    gnt_d      = '0;
    ptr_d      = ptr_q;
    pick_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_found && req_i[k] && (k >= int'(ptr_q))) begin
        gnt_d[k]   = 1'b1;
        pick_found = 1'b1;
        ptr_d      = (k == N_REQ - 1) ? '0 : PTR_W'(k + 1);
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_found && req_i[k]) begin
        gnt_d[k]   = 1'b1;
        pick_found = 1'b1;
        ptr_d      = (k == N_REQ - 1) ? '0 : PTR_W'(k + 1);
      end
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign gnt_o = rst_n ? gnt_d : '0;

  always_comb begin
    addr_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_d[k]) begin
        addr_sel = addr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      rom_en_q <= |gnt_d;
      if (|gnt_d) begin
        rom_addr_q <= addr_sel;
      end
    end
  end

  // Owner tags travel alongside the ROM read so the returned word lands on the right requester.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= ROM_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= gnt_d;
      for (int s = 1; s <= ROM_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_vld_q  <= '0;
    end else begin
      rd_vld_q <= tag_q[ROM_LAT];
      if (|tag_q[ROM_LAT]) begin
        rd_data_q <= rom_data_i;
      end
    end
  end

  always_comb begin
    req_cnt = '0;
    for (int k = 0; k < N_REQ; k++) begin
      req_cnt = req_cnt + 4'(req_i[k]);
    end
  end

  assign contention = (req_cnt >= 4'd2);
  assign vs_fall    = vs_q & ~v_sync_i;

  // Frame clear takes precedence over a coincident contention cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (vs_fall) begin
      cnt_d = '0;
    end else if (contention && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      vs_q  <= 1'b1;
      cnt_q <= '0;
    end else begin
      vs_q  <= v_sync_i;
      cnt_q <= cnt_d;
    end
  end

  assign rom_en_o       = rom_en_q;
  assign rom_addr_o     = rom_addr_q;
  assign rd_data_o      = rd_data_q;
  assign rd_vld_o       = rd_vld_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_sprite_rom_arb.sv
// Scoreboard bench for sprite_rom_arb: expected returns queued at grant time, popped when rd_vld_o fires.
`timescale 1ns/1ps
module tb_sprite_rom_arb;
  localparam int N_REQ   = 4;
  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 13;
  localparam int ROM_LAT = 1;
  localparam int LAT     = ROM_LAT + 2;

  logic                    clk_vga = 1'b0;
  logic                    rst_n   = 1'b0;
  logic [N_REQ-1:0]        req_i   = '0;
  logic [N_REQ*ADDR_W-1:0] addr_i  = '0;
  logic [N_REQ-1:0]        gnt_o;
  logic                    rom_en_o;
  logic [ADDR_W-1:0]       rom_addr_o;
  logic [DATA_W-1:0]       rom_data_i = '0;
  logic [DATA_W-1:0]       rd_data_o;
  logic [N_REQ-1:0]        rd_vld_o;
  logic                    v_sync_i = 1'b1;
  logic [15:0]             conflict_cnt_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mdl_ptr  = 0;
  int mdl_cnt  = 0;
  bit sb_en    = 1'b1;

  typedef struct {
    int               due;
    logic [N_REQ-1:0] vld;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t sb[$];

  sprite_rom_arb #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)) dut (
    .clk_vga(clk_vga), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .gnt_o(gnt_o),
    .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .rd_data_o(rd_data_o), .rd_vld_o(rd_vld_o), .v_sync_i(v_sync_i),
    .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clk_vga = ~clk_vga;
  always @(posedge clk_vga) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    if (a == 14'h0123) return 13'h1ABC;
    return a[12:0] ^ {a[4:0], a[12:5]} ^ 13'h0A5A ^ {12'b0, a[13]};
  endfunction

  // One-cycle synchronous ROM
  always @(posedge clk_vga) if (rom_en_o) rom_data_i <= rom_f(rom_addr_o);

  function automatic logic [N_REQ*ADDR_W-1:0] mkaddr(input logic [13:0] a0, input logic [13:0] a1,
                                                    input logic [13:0] a2, input logic [13:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [N_REQ-1:0] mdl_pick(input logic [N_REQ-1:0] r, input int ptr);
    for (int i = 0; i < N_REQ; i++) begin
      int k;
      k = (ptr + i) % N_REQ;
      if (r[k]) return 4'(1 << k);
    end
    return '0;
  endfunction

  task automatic model_cycle(input logic [N_REQ-1:0] r, input logic [N_REQ*ADDR_W-1:0] a,
                             output logic [N_REQ-1:0] g);
    exp_t e;
    g = mdl_pick(r, mdl_ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (g[k]) begin
        e.due  = cyc + LAT;
        e.vld  = g;
        e.data = rom_f(a[k*ADDR_W +: ADDR_W]);
        sb.push_back(e);
`ifndef SPRITE_ROM_ARB_FIXED_PRIO_EN
        mdl_ptr = (k + 1) % N_REQ;
`endif
      end
    end
    if ($countones(r) >= 2) mdl_cnt++;
  endtask

  task automatic drive(input logic [N_REQ-1:0] r, input logic [N_REQ*ADDR_W-1:0] a, input logic vs);
    @(posedge clk_vga);
    #1;
    req_i    = r;
    addr_i   = a;
    v_sync_i = vs;
    @(negedge clk_vga);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk_vga);
    #1;
    rst_n  = 1'b0;
    req_i  = '0;
    addr_i = '0;
    v_sync_i = 1'b1;
    sb.delete();
    mdl_ptr = 0;
    mdl_cnt = 0;
    repeat (2) @(posedge clk_vga);
    #1;
    rst_n = 1'b1;
    @(negedge clk_vga);
  endtask

  // Scoreboard monitor
  always @(negedge clk_vga) begin
    if (sb_en && rst_n) begin
      if (rd_vld_o !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_vld cyc=%0d got vld=%b data=%h, expected no return", cyc, rd_vld_o, rd_data_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (rd_vld_o !== e.vld || rd_data_o !== e.data || cyc != e.due) begin
            failures++;
            $display("FAIL sb_return cyc=%0d got vld=%b data=%h, expected cyc=%0d vld=%b data=%h",
                     cyc, rd_vld_o, rd_data_o, e.due, e.vld, e.data);
          end
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        checks++;
        failures++;
        $display("FAIL sb_missing cyc=%0d got vld=0, expected vld=%b data=%h at cyc=%0d",
                 cyc, sb[0].vld, sb[0].data, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  task automatic test_reset();
    logic [N_REQ-1:0] g;
    logic [N_REQ*ADDR_W-1:0] a;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_vga);
      #1;
      req_i  = 4'($urandom_range(0, 15));
      addr_i = {$urandom(), $urandom()};
      @(negedge clk_vga);
      checks++;
      if ({gnt_o, rom_en_o, rom_addr_o, rd_data_o, rd_vld_o, conflict_cnt_o} !== '0) begin
        failures++;
        $display("FAIL reset_outputs gnt=%b en=%b addr=%h data=%h vld=%b cnt=%0d, expected all 0",
                 gnt_o, rom_en_o, rom_addr_o, rd_data_o, rd_vld_o, conflict_cnt_o);
      end
    end
    @(posedge clk_vga);
    #1;
    rst_n  = 1'b1;
    req_i  = 4'b1010;
    a      = mkaddr(14'h0011, 14'h0022, 14'h0033, 14'h0044);
    addr_i = a;
    @(negedge clk_vga);
    model_cycle(4'b1010, a, g);
    checks++;
    if (gnt_o !== 4'b0010) begin
      failures++;
      $display("FAIL reset_first_grant got=%b expected=0010", gnt_o);
    end
    idle(LAT + 1);
  endtask

  task automatic test_single();
    logic [N_REQ*ADDR_W-1:0] a;
    logic [N_REQ-1:0] g;
    a = mkaddr(14'h3FFF, 14'h0123, 14'h0555, 14'h0AAA);
    drive(4'b0010, a, 1'b1);
    model_cycle(4'b0010, a, g);
    checks++;
    if (gnt_o !== 4'b0010) begin
      failures++;
      $display("FAIL single_gnt got=%b expected=0010", gnt_o);
    end
    idle(1);
    checks++;
    if (rom_en_o !== 1'b1 || rom_addr_o !== 14'h0123) begin
      failures++;
      $display("FAIL single_rom_port got en=%b addr=%h expected en=1 addr=0123", rom_en_o, rom_addr_o);
    end
    idle(1);
    checks++;
    if (rom_en_o !== 1'b0 || rom_addr_o !== 14'h0123) begin
      failures++;
      $display("FAIL single_rom_hold got en=%b addr=%h expected en=0 addr=0123", rom_en_o, rom_addr_o);
    end
    idle(1);
    checks++;
    if (rd_vld_o !== 4'b0010 || rd_data_o !== 13'h1ABC) begin
      failures++;
      $display("FAIL single_return got vld=%b data=%h expected vld=0010 data=1abc", rd_vld_o, rd_data_o);
    end
    idle(3);
    checks++;
    if (rd_vld_o !== 4'b0000 || rd_data_o !== 13'h1ABC) begin
      failures++;
      $display("FAIL single_data_hold got vld=%b data=%h expected vld=0000 data=1abc", rd_vld_o, rd_data_o);
    end
  endtask

  task automatic test_contention();
    logic [N_REQ*ADDR_W-1:0] a;
    logic [N_REQ-1:0] g;
    logic [N_REQ-1:0] want;
    do_reset();
    a = mkaddr(14'h0100, 14'h0211, 14'h0322, 14'h0433);
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, a, 1'b1);
      model_cycle(4'b1111, a, g);
`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
      want = 4'b0001;
`else
      want = 4'(1 << (i % N_REQ));
`endif
      checks++;
      if (gnt_o !== want) begin
        failures++;
        $display("FAIL contention_gnt[%0d] got=%b expected=%b", i, gnt_o, want);
      end
    end
    idle(1);
    checks++;
    if (conflict_cnt_o !== 16'd8) begin
      failures++;
      $display("FAIL contention_cnt got=%0d expected=8", conflict_cnt_o);
    end
    idle(LAT + 1);
  endtask

  task automatic test_back_to_back();
    logic [N_REQ*ADDR_W-1:0] a;
    logic [N_REQ-1:0] g;
    for (int i = 0; i < 4; i++) begin
      a = mkaddr(14'h0777, 14'h0888, 14'(i), 14'h0999);
      drive(4'b0100, a, 1'b1);
      model_cycle(4'b0100, a, g);
      checks++;
      if (gnt_o !== 4'b0100) begin
        failures++;
        $display("FAIL stream_gnt[%0d] got=%b expected=0100", i, gnt_o);
      end
    end
    idle(LAT + 2);
  endtask

  task automatic test_random();
    logic [N_REQ*ADDR_W-1:0] a;
    logic [N_REQ-1:0] r;
    logic [N_REQ-1:0] g;
    drive('0, '0, 1'b0);
    mdl_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      r = 4'($urandom_range(0, 15));
      a = {$urandom(), $urandom()};
      drive(r, a, 1'b1);
      model_cycle(r, a, g);
      checks++;
      if (gnt_o !== g) begin
        failures++;
        $display("FAIL random_gnt[%0d] req=%b got=%b expected=%b", i, r, gnt_o, g);
      end
    end
    idle(1);
    checks++;
    if (conflict_cnt_o !== 16'(mdl_cnt)) begin
      failures++;
      $display("FAIL random_cnt got=%0d expected=%0d", conflict_cnt_o, mdl_cnt);
    end
    idle(LAT + 1);
  endtask

  task automatic test_counter();
    logic [N_REQ*ADDR_W-1:0] a;
    a = mkaddr(14'h0001, 14'h0002, 14'h0003, 14'h0004);
    sb_en = 1'b0;
    drive('0, '0, 1'b0);
    drive('0, '0, 1'b1);
    checks++;
    if (conflict_cnt_o !== 16'd0) begin
      failures++;
      $display("FAIL counter_vsync_clear got=%0d expected=0", conflict_cnt_o);
    end
    for (int n = 0; n < 70000; n++) begin
      drive(4'b1111, a, 1'b1);
      if (n == 65534) begin
        checks++;
        if (conflict_cnt_o !== 16'hFFFE) begin
          failures++;
          $display("FAIL counter_pre_sat got=%h expected=fffe", conflict_cnt_o);
        end
      end
      if (n == 65535) begin
        checks++;
        if (conflict_cnt_o !== 16'hFFFF) begin
          failures++;
          $display("FAIL counter_at_sat got=%h expected=ffff", conflict_cnt_o);
        end
      end
    end
    drive('0, '0, 1'b1);
    checks++;
    if (conflict_cnt_o !== 16'hFFFF) begin
      failures++;
      $display("FAIL counter_saturated got=%h expected=ffff", conflict_cnt_o);
    end
    drive(4'b1111, a, 1'b0);
    drive(4'b1111, a, 1'b0);
    checks++;
    if (conflict_cnt_o !== 16'd0) begin
      failures++;
      $display("FAIL counter_clear_wins got=%0d expected=0", conflict_cnt_o);
    end
    drive('0, '0, 1'b1);
    checks++;
    if (conflict_cnt_o !== 16'd1) begin
      failures++;
      $display("FAIL counter_after_clear got=%0d expected=1", conflict_cnt_o);
    end
    idle(LAT + 2);
    sb.delete();
    sb_en = 1'b1;
  endtask

  task automatic test_reset_inflight();
    logic [N_REQ*ADDR_W-1:0] a;
    logic [N_REQ-1:0] g;
    do_reset();
    a = mkaddr(14'h0101, 14'h0202, 14'h0303, 14'h0404);
    drive(4'b0001, a, 1'b1);
    model_cycle(4'b0001, a, g);
    drive(4'b0010, a, 1'b1);
    model_cycle(4'b0010, a, g);
    checks++;
    if (gnt_o !== 4'b0010) begin
      failures++;
      $display("FAIL inflight_second_gnt got=%b expected=0010", gnt_o);
    end
    @(posedge clk_vga);
    #1;
    req_i  = '0;
    rst_n  = 1'b0;
    sb.delete();
    mdl_ptr = 0;
    #2;
    rst_n = 1'b1;
    @(negedge clk_vga);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rd_vld_o !== '0 || rom_en_o !== 1'b0) begin
        failures++;
        $display("FAIL inflight_no_vld[%0d] got vld=%b en=%b expected vld=0000 en=0", i, rd_vld_o, rom_en_o);
      end
      idle(1);
    end
    drive(4'b1000, a, 1'b1);
    model_cycle(4'b1000, a, g);
    checks++;
    if (gnt_o !== 4'b1000) begin
      failures++;
      $display("FAIL inflight_regrant got=%b expected=1000", gnt_o);
    end
    idle(LAT + 1);
  endtask

`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    logic [N_REQ*ADDR_W-1:0] a;
    logic [N_REQ-1:0] g;
    a = mkaddr(14'h0005, 14'h0006, 14'h0007, 14'h0008);
    for (int i = 0; i < 6; i++) begin
      drive(4'b1111, a, 1'b1);
      model_cycle(4'b1111, a, g);
      checks++;
      if (gnt_o !== 4'b0001) begin
        failures++;
        $display("FAIL fixed_prio_gnt[%0d] got=%b expected=0001", i, gnt_o);
      end
    end
    idle(LAT + 1);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_random();
    test_counter();
    test_reset_inflight();
`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    idle(4);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d pending expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arb.md
Name: sprite_rom_arb

Overview:
Arbiter that shares one synchronous sprite ROM among several sprite renderers (me, enemy, bonus, info) in the VGA pixel clock domain. It takes per-requester read requests, grants one per cycle (round-robin by default), drives the ROM address port, and routes the returned pixel word (RGB plus alpha) back to the requester that issued it. It also keeps a per-frame contention counter for debug and overlay display.

Parameters:
N_REQ, 4, number of requesters (legal range 2..8)
ADDR_W, 14, ROM address width
DATA_W, 13, ROM word width: {alpha, RGB[11:0]}
ROM_LAT, 1, ROM read latency in cycles, measured from the cycle rom_en_o is high to the cycle rom_data_i is valid (legal range 1..3)

Ports:
clk_vga  in  1  pixel clock; all state is on its rising edge
rst_n  in  1  asynchronous reset, active-low
req_i  in  N_REQ  per-requester read request; bit k belongs to requester k
addr_i  in  N_REQ*ADDR_W  packed addresses; slice k is [k*ADDR_W +: ADDR_W]
gnt_o  out  N_REQ  one-hot grant; combinational within the cycle
rom_en_o  out  1  ROM read enable (registered)
rom_addr_o  out  ADDR_W  ROM address (registered)
rom_data_i  in  DATA_W  ROM read data
rd_data_o  out  DATA_W  returned word (registered)
rd_vld_o  out  N_REQ  one-hot, marks which requester owns rd_data_o
v_sync_i  in  1  VGA vsync (active-low)
conflict_cnt_o  out  16  count of contention cycles in the current frame

Behaviour:
- Reset values: rom_en_o=0, rom_addr_o=0, rd_data_o=0, rd_vld_o=0, conflict_cnt_o=0, RR pointer=0, tag pipe=0, vsync delay reg=1.
- Handshake:
  - A requester holds req_i[k] and its address stable until it sees gnt_o[k]=1. That cycle consumes the address.
  - Keeping req_i high with a new address in the next cycle gives back-to-back reads.
  - Deasserting req_i without a grant is legal; the request is dropped.
- Arbitration:
  - Round-robin search starting at the pointer.
  - At most one gnt_o bit is high per cycle. gnt_o is 0 when req_i=0.
  - After granting k, the pointer becomes (k+1) mod N_REQ. It is unchanged when there is no grant.
- Grant cycle G:
  - At the end of G: rom_en_o<=1, rom_addr_o<=addr_i slice k, tag stage 0<=onehot(k).
  - With no grant: rom_en_o<=0, rom_addr_o holds its value, tag stage 0<=0.
- Tag pipe:
  - ROM_LAT+1 stages of N_REQ bits, shifting every cycle.
  - rom_data_i is valid in cycle G+1+ROM_LAT.
  - At the end of that cycle, rd_data_o<=rom_data_i and rd_vld_o<=final tag stage.
  - So rd_vld_o[k] is high in cycle G+2+ROM_LAT, a fixed latency of ROM_LAT+2 cycles from the grant.
  - rd_data_o holds its value when rd_vld_o=0.
- Throughput: one read per cycle sustained. Results return in grant order.
- Contention counter:
  - A contention cycle is any cycle with popcount(req_i)>=2.
  - conflict_cnt_o increments by 1 on each contention cycle and saturates at 16'hFFFF.
  - It is cleared on the falling edge of v_sync_i (delay reg=1, v_sync_i=0).
  - When clear and a contention cycle coincide, clear wins and the result is 0.
- Reset mid-operation: all in-flight tags are discarded. No rd_vld_o pulse occurs after rst_n deasserts until a new grant.

Optional Feature:
SPRITE_ROM_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins (requester 0 highest). The RR pointer is not implemented. The contention counter is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset: hold rst_n=0 with random req_i/addr_i -> all outputs 0, gnt_o=0 (ROM_LAT=1); release rst_n -> first grant goes to the lowest active index.
- Single read: req_i=4'b0010, slice 1=14'h0123, ROM model returns 13'h1ABC -> gnt_o=4'b0010 in cycle G; rom_addr_o=14'h0123 with rom_en_o=1 in G+1; rd_vld_o=4'b0010 and rd_data_o=13'h1ABC in G+3.
- Full contention: req_i=4'b1111 held for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3; conflict_cnt_o reaches 8; rd_vld_o follows the same order 3 cycles later.
- Streaming: requester 2 presents addresses 0,1,2,3 on consecutive cycles with req held -> 4 consecutive grants; rd_data_o returns ROM[0..3] in order on 4 consecutive cycles.
- Counter: force 70000 contention cycles -> saturates at 65535; v_sync_i falling edge coinciding with a contention cycle -> 0 in the next cycle.
- Reset in flight: two grants issued, then pulse rst_n low before data returns -> no rd_vld_o afterwards. With SPRITE_ROM_ARB_FIXED_PRIO_EN defined and req_i=4'b1111 -> gnt_o=4'b0001 every cycle.
